// File: rtl/alu_result_sender_if.sv
// Handshake bundle between the ALU result port, the result sender and the UART TX byte port.
// The sender uses the slave view; the producer/consumer environment uses the master view.
interface alu_result_sender_if #(
    parameter int data_width = 8
);
    logic [2*data_width-1:0] ALU_OUT;
    logic                    out_valid;
    logic                    alu_ready;
    logic [data_width-1:0]   TX_P_DATA;
    logic                    TX_D_VALID;
    logic                    TX_READY;
    logic                    busy;
    logic                    overflow;

    modport master (
        output ALU_OUT, out_valid, TX_READY,
        input  alu_ready, TX_P_DATA, TX_D_VALID, busy, overflow
    );

    modport slave (
        input  ALU_OUT, out_valid, TX_READY,
        output alu_ready, TX_P_DATA, TX_D_VALID, busy, overflow
    );
endinterface

// File: rtl/alu_result_sender.sv
// Buffers 2*data_width-bit ALU results in a small FIFO and streams each one to the
// UART TX as two bytes, LSB first, over a valid/ready handshake.
module alu_result_sender #(
    parameter int data_width = 8,
    parameter int fifo_depth = 2
) (
    input logic              CLK,
    input logic              rst,
    alu_result_sender_if.slave bus
);
    localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_w = ptr_w + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_LSB = 2'd1,
        SEND_MSB = 2'd2
    } state_t;

    logic [2*data_width-1:0] mem [fifo_depth];
    logic [ptr_w-1:0]        wr_ptr;
    logic [ptr_w-1:0]        rd_ptr;
    logic [cnt_w-1:0]        count;
    state_t                  state;
    logic [2*data_width-1:0] hold;
    logic [data_width-1:0]   tx_data;
    logic                    tx_valid;
    logic                    overflow_q;

    logic                    full;
    logic                    not_empty;
    logic                    push;
    logic                    pop;
    logic [2*data_width-1:0] head;

    assign full      = (count == cnt_w'(fifo_depth));
    assign not_empty = (count != '0);
    assign push      = bus.out_valid && !full;
    assign head      = mem[rd_ptr];

    // A pop happens only when the FSM is ready to load a new frame into hold.
    always_comb begin
        // NOTE: default first so every path assigns pop and no latch is inferred.
        pop = 1'b0;
        case (state)
            IDLE:     pop = not_empty;
            SEND_MSB: pop = bus.TX_READY && not_empty;
            default:  pop = 1'b0;
        endcase
    end

    // NOTE: the storage array carries no reset; pointers and count define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.ALU_OUT;
    end

    // NOTE: all sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            state      <= IDLE;
            hold       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (bus.out_valid && full) overflow_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        hold     <= head;
                        tx_data  <= head[data_width-1:0];
                        tx_valid <= 1'b1;
                        state    <= SEND_LSB;
                    end else begin
                        tx_valid <= 1'b0;
                    end
                end
                SEND_LSB: begin
                    if (bus.TX_READY) begin
                        tx_data <= hold[2*data_width-1:data_width];
                        state   <= SEND_MSB;
                    end
                end
                SEND_MSB: begin
                    if (bus.TX_READY) begin
                        if (pop) begin
                            hold    <= head;
                            tx_data <= head[data_width-1:0];
                            state   <= SEND_LSB;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_P_DATA  = tx_data;
    assign bus.TX_D_VALID = tx_valid;
    assign bus.alu_ready  = !full;
    assign bus.busy       = (state != IDLE) || not_empty;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_alu_result_sender.sv
// Self-checking bench for alu_result_sender: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_alu_result_sender;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic rst;

    alu_result_sender_if #(.data_width(DW)) bus ();

    alu_result_sender #(.data_width(DW), .fifo_depth(DEPTH)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: pending results and the bytes of the frame being presented.
    logic [2*DW-1:0] m_fifo[$];
    logic [DW-1:0]   m_frame[$];
    bit              m_ovf;
    logic [DW-1:0]   exp_stream[$];
    logic [DW-1:0]   rx_stream[$];

    typedef struct {
        bit          ov;
        logic [15:0] d;
        bit          rdy;
        bit          e_valid;
        logic [7:0]  e_data;
        bit          e_ready;
        bit          e_busy;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_frame.delete();
        m_ovf = 1'b0;
    endtask

    task automatic clear_streams();
        exp_stream.delete();
        rx_stream.delete();
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare outputs.
    task automatic step(input bit ov, input logic [15:0] d, input bit rdy);
        logic [2*DW-1:0] w;
        int pre;
        bus.out_valid = ov;
        bus.ALU_OUT   = d;
        bus.TX_READY  = rdy;
        if (bus.TX_D_VALID === 1'b1 && rdy) rx_stream.push_back(bus.TX_P_DATA);
        @(posedge CLK);
        pre = m_fifo.size();
        if (m_frame.size() > 0 && rdy) void'(m_frame.pop_front());
        if (m_frame.size() == 0 && pre > 0) begin
            w = m_fifo.pop_front();
            m_frame.push_back(w[DW-1:0]);
            m_frame.push_back(w[2*DW-1:DW]);
        end
        if (ov) begin
            if (pre < DEPTH) begin
                m_fifo.push_back(d);
                exp_stream.push_back(d[DW-1:0]);
                exp_stream.push_back(d[2*DW-1:DW]);
            end else begin
                m_ovf = 1'b1;
            end
        end
        #1;
        check("model_valid", 32'(bus.TX_D_VALID), 32'(m_frame.size() > 0));
        if (m_frame.size() > 0) check("model_data", 32'(bus.TX_P_DATA), 32'(m_frame[0]));
        check("model_alu_ready", 32'(bus.alu_ready), 32'(m_fifo.size() != DEPTH));
        check("model_busy", 32'(bus.busy), 32'(m_frame.size() > 0 || m_fifo.size() > 0));
        check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic compare_streams(input string name);
        check({name, "_len"}, 32'(rx_stream.size()), 32'(exp_stream.size()));
        for (int i = 0; i < exp_stream.size() && i < rx_stream.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(rx_stream[i]), 32'(exp_stream[i]));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 32'(bus.TX_D_VALID), 32'(0));
        check({name, "_data"},  32'(bus.TX_P_DATA),  32'(0));
        check({name, "_ready"}, 32'(bus.alu_ready),  32'(1));
        check({name, "_busy"},  32'(bus.busy),       32'(0));
        check({name, "_ovf"},   32'(bus.overflow),   32'(0));
    endtask

    initial begin
        logic [7:0] exp3[6];
        bit         saw_not_ready;

        tbl[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        exp3[0] = 8'h01; exp3[1] = 8'h00; exp3[2] = 8'h02;
        exp3[3] = 8'h00; exp3[4] = 8'h03; exp3[5] = 8'h00;

        // Reset state
        bus.out_valid = 1'b0;
        bus.ALU_OUT   = '0;
        bus.TX_READY  = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK) rst = 1'b0;
        @(posedge CLK);
        #1;

        // Vector table: single frame, then a stalled LSB
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].ov, tbl[i].d, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), 32'(bus.TX_D_VALID), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                check($sformatf("tbl%0d_data", i), 32'(bus.TX_P_DATA), 32'(tbl[i].e_data));
            check($sformatf("tbl%0d_ready", i), 32'(bus.alu_ready), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_busy", i),  32'(bus.busy),      32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_ovf", i),   32'(bus.overflow),  32'(tbl[i].e_ovf));
        end

        // Fill while TX stalls; the fourth push overflows
        clear_streams();
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        check("fill_alu_ready", 32'(bus.alu_ready), 32'(0));
        check("fill_ovf_clear", 32'(bus.overflow),  32'(0));
        step(1'b1, 16'h0004, 1'b0);
        check("fill_ovf_set", 32'(bus.overflow), 32'(1));
        repeat (2) step(1'b0, 16'h0000, 1'b0);
        repeat (8) step(1'b0, 16'h0000, 1'b1);
        check("fill_len", 32'(rx_stream.size()), 32'(6));
        for (int i = 0; i < 6 && i < rx_stream.size(); i++)
            check($sformatf("fill_byte%0d", i), 32'(rx_stream[i]), 32'(exp3[i]));
        check("fill_ovf_sticky", 32'(bus.overflow), 32'(1));

        // Back-to-back pushes with TX always ready
        clear_streams();
        saw_not_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(16'h0100 + i), 1'b1);
            if (!bus.alu_ready) saw_not_ready = 1'b1;
        end
        repeat (10) step(1'b0, 16'h0000, 1'b1);
        check("b2b_ready_dropped", 32'(saw_not_ready), 32'(1));
        compare_streams("b2b");

        // Reset in the middle of a frame after the LSB is accepted
        clear_streams();
        step(1'b1, 16'hCAFE, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        check("mid_msb_shown", 32'(bus.TX_P_DATA), 32'(8'hCA));
        bus.TX_READY = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        clear_streams();
        @(negedge CLK) rst = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b1, 16'hBEEF, 1'b1);
        repeat (5) step(1'b0, 16'h0000, 1'b1);
        check("midrst_len", 32'(rx_stream.size()), 32'(2));
        if (rx_stream.size() == 2) begin
            check("midrst_lsb", 32'(rx_stream[0]), 32'(8'hEF));
            check("midrst_msb", 32'(rx_stream[1]), 32'(8'hBE));
        end

        // Simultaneous push and pop with one entry buffered
        clear_streams();
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        check("pp_ready_count1", 32'(bus.alu_ready), 32'(1));
        step(1'b1, 16'h3333, 1'b0);
        check("pp_ready_full", 32'(bus.alu_ready), 32'(0));
        check("pp_no_ovf", 32'(bus.overflow), 32'(0));
        repeat (8) step(1'b0, 16'h0000, 1'b1);
        compare_streams("pp");

        // Randomized traffic against the model
        clear_streams();
        for (int i = 0; i < 400; i++)
            step(bit'($urandom_range(0, 1)), 16'($urandom), bit'($urandom_range(0, 3) != 0));
        repeat (10) step(1'b0, 16'h0000, 1'b1);
        compare_streams("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
